dm_write_buffer: RTL and testbench

- Store write buffer directly downstream of the MEM-stage store byte-enable/data alignment logic, upstream of the data memory port.
- Accepts aligned stores (word address, 4-bit byte enable, lane-aligned data), queues them in order and drains one per memory acknowledge.
- Flags loads whose bytes overlap any pending store so the hazard unit can stall the load.

---
 rtl/dm_write_buffer_pkg.sv | 17 +
 rtl/dm_wb_match.sv | 15 +
 rtl/dm_write_buffer.sv | 100 ++++++++++
 tb/tb_dm_write_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_write_buffer_pkg.sv
// Shared types and constants for the MEM-stage store write buffer.
package dm_write_buffer_pkg;

    localparam logic [3:0] WE_NONE    = 4'b0000;
    localparam logic [3:0] WE_WORD    = 4'b1111;
    localparam logic [3:0] WE_HALF_LO = 4'b0011;
    localparam logic [3:0] WE_HALF_HI = 4'b1100;

    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dm_wb_match.sv
// Per-entry load/store overlap detector: same word and at least one shared byte.
module dm_wb_match
    import dm_write_buffer_pkg::*;
(
    input  logic        i_valid,
    input  logic [29:0] i_word_addr,
    input  logic [3:0]  i_we,
    input  logic [29:0] i_ld_word_addr,
    input  logic [3:0]  i_ld_be,
    output logic        o_hit
);

    assign o_hit = i_valid && (i_word_addr == i_ld_word_addr) && ((i_we & i_ld_be) != WE_NONE);

endmodule

// File: rtl/dm_write_buffer.sv
// In-order store write buffer between MEM-stage store alignment and the data memory port.
module dm_write_buffer
    import dm_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_addr,
    input  logic [3:0]       in_we,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_be,
    output logic             ld_conflict,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_we,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] r_valid;
    wb_entry_t        r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hits;
    wb_entry_t        w_head;
    logic             w_unused_addr_lsbs;

    // Byte offsets are implied by the lane-aligned byte enables.
    assign w_unused_addr_lsbs = &{1'b0, in_addr[1:0], ld_addr[1:0]};

    assign empty    = (r_count == '0);
    assign in_ready = (r_count != FULL_COUNT);
    assign mem_req  = !empty;
    assign count    = r_count;

    assign w_push = in_valid && in_ready && (in_we != WE_NONE);
    assign w_pop  = mem_req && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head and tail never coincide when both fire, so clear/set order is irrelevant.
            if (w_pop)  r_valid[r_head] <= 1'b0;
            if (w_push) r_valid[r_tail] <= 1'b1;
        end
    end

    // NOTE: payload storage is deliberately left unreset; the valid bits alone qualify entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= '{word_addr: in_addr[31:2], we: in_we, data: in_data};
    end

    always_comb begin
        w_head = '0;
        if (!empty) w_head = r_mem[r_head];
    end

    assign mem_addr  = {w_head.word_addr, 2'b00};
    assign mem_we    = w_head.we;
    assign mem_wdata = w_head.data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        dm_wb_match u_match (
            .i_valid        (r_valid[g]),
            .i_word_addr    (r_mem[g].word_addr),
            .i_we           (r_mem[g].we),
            .i_ld_word_addr (ld_addr[31:2]),
            .i_ld_be        (ld_be),
            .o_hit          (w_hits[g])
        );
    end

    assign ld_conflict = ld_valid && (|w_hits);

endmodule

// File: tb/tb_dm_write_buffer.sv
// Self-checking bench for dm_write_buffer: directed vector table, reset sequence, random vs queue model.
module tb_dm_write_buffer;
    import dm_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic [3:0]  in_we = '0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_be = '0;
    logic        ld_conflict;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [2:0]  count;
    logic        empty;

    dm_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_we       (in_we),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_be       (ld_be),
        .ld_conflict (ld_conflict),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .count       (count),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic [3:0]  iw;
        logic [31:0] id;
        logic        lv;
        logic [31:0] la;
        logic [3:0]  lb;
        logic        ack;
        logic        e_ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_conf;
        logic [2:0]  e_count;
    } vec_t;

    typedef struct {
        logic [31:0] byte_addr;
        logic [3:0]  we;
        logic [31:0] data;
    } store_t;

    vec_t   tv[$];
    store_t model_q[$];
    int     n_vec  = 0;
    int     n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic [3:0] iw,
                                input logic [31:0] id, input logic lv, input logic [31:0] la,
                                input logic [3:0] lb, input logic ack, input logic e_ready,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic e_conf,
                                input logic [2:0] e_count);
        vec_t v;
        v = '{iv, ia, iw, id, lv, la, lb, ack, e_ready, e_req, e_addr, e_wdata, e_conf, e_count};
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ia, input logic [3:0] iw,
                         input logic [31:0] id, input logic lv, input logic [31:0] la,
                         input logic [3:0] lb, input logic ack);
        in_valid = iv; in_addr = ia; in_we = iw; in_data = id;
        ld_valid = lv; ld_addr = la; ld_be = lb; mem_ack = ack;
    endtask

    // Expected outputs follow from the list of pending stores, oldest first.
    task automatic model_check(input string tag);
        logic        conf;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_data;
        conf = 1'b0;
        foreach (model_q[i])
            if (ld_valid && model_q[i].byte_addr[31:2] == ld_addr[31:2] && (model_q[i].we & ld_be) != 0)
                conf = 1'b1;
        e_addr = 0; e_we = 0; e_data = 0;
        if (model_q.size() > 0) begin
            e_addr = {model_q[0].byte_addr[31:2], 2'b00};
            e_we   = model_q[0].we;
            e_data = model_q[0].data;
        end
        check({tag, ".count"},       32'(count),       32'(model_q.size()));
        check({tag, ".in_ready"},    32'(in_ready),    32'(model_q.size() != DEPTH));
        check({tag, ".empty"},       32'(empty),       32'(model_q.size() == 0));
        check({tag, ".mem_req"},     32'(mem_req),     32'(model_q.size() != 0));
        check({tag, ".mem_addr"},    mem_addr,         e_addr);
        check({tag, ".mem_we"},      32'(mem_we),      32'(e_we));
        check({tag, ".mem_wdata"},   mem_wdata,        e_data);
        check({tag, ".ld_conflict"}, 32'(ld_conflict), 32'(conf));
    endtask

    task automatic model_advance();
        logic do_push;
        logic do_pop;
        do_push = in_valid && (model_q.size() < DEPTH) && (in_we != 0);
        do_pop  = mem_ack && (model_q.size() > 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back('{in_addr, in_we, in_data});
    endtask

    // Called on a falling edge: settle, check, cross one rising edge, return on the next falling edge.
    task automatic step(input string tag);
        #1;
        model_check(tag);
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        // Directed table: expectations are the values seen before the edge that applies the inputs.
        tv.push_back(mk(1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h100, 32'hDEADBEEF, 0, 1));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h0,  4'hF, 32'hA0,        0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h4,  4'hF, 32'hA1,        0, 0, 0, 0,  1, 1, 32'h0,   32'hA0,       0, 1));
        tv.push_back(mk(1, 32'h8,  4'hF, 32'hA2,        0, 0, 0, 0,  1, 1, 32'h0,   32'hA0,       0, 2));
        tv.push_back(mk(1, 32'hC,  4'hF, 32'hA3,        0, 0, 0, 0,  1, 1, 32'h0,   32'hA0,       0, 3));
        tv.push_back(mk(1, 32'h10, 4'hF, 32'hA4,        0, 0, 0, 0,  0, 1, 32'h0,   32'hA0,       0, 4));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  0, 1, 32'h0,   32'hA0,       0, 4));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h4,   32'hA1,       0, 3));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h8,   32'hA2,       0, 2));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'hC,   32'hA3,       0, 1));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h20, 4'hF, 32'hB0,        0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h24, 4'hF, 32'hB1,        0, 0, 0, 0,  1, 1, 32'h20,  32'hB0,       0, 1));
        tv.push_back(mk(1, 32'h28, 4'hF, 32'hB2,        0, 0, 0, 0,  1, 1, 32'h20,  32'hB0,       0, 2));
        tv.push_back(mk(1, 32'h2C, 4'hF, 32'hB3,        0, 0, 0, 0,  1, 1, 32'h20,  32'hB0,       0, 3));
        tv.push_back(mk(1, 32'h30, 4'hF, 32'hB4,        0, 0, 0, 1,  0, 1, 32'h20,  32'hB0,       0, 4));
        tv.push_back(mk(1, 32'h30, 4'hF, 32'hB4,        0, 0, 0, 0,  1, 1, 32'h24,  32'hB1,       0, 3));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  0, 1, 32'h24,  32'hB1,       0, 4));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h28,  32'hB2,       0, 3));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h2C,  32'hB3,       0, 2));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 1,  1, 1, 32'h30,  32'hB4,       0, 1));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h201, 4'b0010, 32'hAB00,  0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 32'h200, 4'b0011, 0,         1, 1, 32'h200, 32'hAB00,     1, 1));
        tv.push_back(mk(0, 0, 0, 0,  1, 32'h200, 4'b1100, 0,         1, 1, 32'h200, 32'hAB00,     0, 1));
        tv.push_back(mk(0, 0, 0, 0,  1, 32'h204, 4'b1111, 0,         1, 1, 32'h200, 32'hAB00,     0, 1));
        tv.push_back(mk(0, 0, 0, 0,  0, 32'h200, 4'b0011, 0,         1, 1, 32'h200, 32'hAB00,     0, 1));
        tv.push_back(mk(0, 0, 0, 0,  1, 32'h200, 4'b0011, 1,         1, 1, 32'h200, 32'hAB00,     1, 1));
        tv.push_back(mk(1, 32'h300, 4'h0, 32'h12345678, 0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));
        tv.push_back(mk(1, 32'h400, 4'hF, 32'h55AA55AA, 1, 32'h400, 4'hF, 0, 1, 0, 32'h0, 32'h0,  0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 32'h400, 4'b0001, 1,         1, 1, 32'h400, 32'h55AA55AA, 1, 1));
        tv.push_back(mk(0, 0, 0, 0,                     0, 0, 0, 0,  1, 0, 32'h0,   32'h0,        0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst.count",    32'(count),    32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.mem_req",  32'(mem_req),  32'd0);
        check("rst.empty",    32'(empty),    32'd1);
        check("rst.mem_addr", mem_addr,      32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            drive(tv[i].iv, tv[i].ia, tv[i].iw, tv[i].id, tv[i].lv, tv[i].la, tv[i].lb, tv[i].ack);
            #1;
            check($sformatf("tv%0d.count", i),       32'(count),       32'(tv[i].e_count));
            check($sformatf("tv%0d.in_ready", i),    32'(in_ready),    32'(tv[i].e_ready));
            check($sformatf("tv%0d.mem_req", i),     32'(mem_req),     32'(tv[i].e_req));
            check($sformatf("tv%0d.mem_addr", i),    mem_addr,         tv[i].e_addr);
            check($sformatf("tv%0d.mem_wdata", i),   mem_wdata,        tv[i].e_wdata);
            check($sformatf("tv%0d.ld_conflict", i), 32'(ld_conflict), 32'(tv[i].e_conf));
            step($sformatf("tv%0d.model", i));
        end

        // Asynchronous reset while three stores are pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500 + 32'(4 * i), 4'hF, 32'hC0 + 32'(i), 0, 0, 0, 0);
            step("fill3");
        end
        drive(0, 0, 0, 0, 1, 32'h500, 4'hF, 0);
        #1;
        check("pre_rst.count",   32'(count),   32'd3);
        check("pre_rst.mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.mem_req",     32'(mem_req),     32'd0);
        check("async_rst.count",       32'(count),       32'd0);
        check("async_rst.in_ready",    32'(in_ready),    32'd1);
        check("async_rst.ld_conflict", 32'(ld_conflict), 32'd0);
        check("async_rst.mem_wdata",   mem_wdata,        32'd0);
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 32'h600, 4'hF, 32'h600D, 0, 0, 0, 0);
        step("post_rst.push");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("post_rst.mem_addr",  mem_addr,  32'h600);
        check("post_rst.mem_wdata", mem_wdata, 32'h600D);
        step("post_rst.model");

        // Random traffic over a small address pool so overlaps and fills happen often.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] we_r;
            logic [3:0] be_r;
            case ($urandom_range(0, 5))
                0:       we_r = WE_NONE;
                1:       we_r = WE_WORD;
                2:       we_r = WE_HALF_LO;
                3:       we_r = WE_HALF_HI;
                4:       we_r = 4'(1 << $urandom_range(0, 3));
                default: we_r = 4'($urandom);
            endcase
            be_r = 4'($urandom_range(1, 15));
            drive($urandom_range(0, 9) < 6, {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)}, we_r,
                  $urandom, $urandom_range(0, 3) != 0, {26'h0, 4'($urandom_range(0, 7)), 2'b00},
                  be_r, $urandom_range(0, 9) < 4);
            step("rand");
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
